// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: difference = a - b - borrow_in, one bit per clock, LSB first.
// Latency: start accepted at edge 0, result and done pulse appear after edge NUM_BITS.
// Backpressure: none; start is only honoured in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, n_rst        : clock and synchronous active-low reset
//   start             : operation request, sampled in IDLE or DONE
//   a, b, borrow_in   : operands, captured on the accepted start edge
//   busy              : high while the operation is shifting
//   done              : one-cycle pulse when difference/borrow_out are fresh
//   difference        : registered result, held until the next operation completes
//   borrow_out        : registered final borrow, high when a < b + borrow_in
module serial_subtractor #(
    parameter int NUM_BITS = 8
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                borrow_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] difference,
    output logic                borrow_out
);

    localparam int CW = $clog2(NUM_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic [NUM_BITS-1:0] sh_q, sh_d;      // difference bits accumulate here, MSB-inserted
    logic                br_q, br_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_BITS-1:0] diff_q, diff_d;
    logic                bout_q, bout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Full-subtractor on the current LSBs.
    logic                bit_d;
    logic                br_nxt;
    logic [NUM_BITS-1:0] sh_nxt;
    logic                last_shift;

    assign bit_d      = a_q[0] ^ b_q[0] ^ br_q;
    assign br_nxt     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    assign sh_nxt     = {bit_d, sh_q[NUM_BITS-1:1]};
    assign last_shift = (cnt_q == CW'(NUM_BITS - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = borrow_in;
                    sh_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sh_d  = sh_nxt;
                br_d  = br_nxt;
                cnt_d = cnt_q + CW'(1);
                if (last_shift) begin
                    // Publish the full word including the bit computed this cycle.
                    diff_d  = sh_nxt;
                    bout_d  = br_nxt;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sh_q    <= sh_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign difference = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor: scoreboard of expected results, monitor on done.
// Latency: checks busy/done cycle by cycle against the fixed NUM_BITS+1 schedule.
// Backpressure: exercises ignored start during SHIFT and back-to-back starts in DONE.
module tb_serial_subtractor;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [N-1:0] difference;
    logic         borrow_out;

    serial_subtractor #(.NUM_BITS(N)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] d;
        logic         bo;
    } res_t;

    res_t exp_q[$];
    res_t hold;
    int   total = 0;
    int   bad   = 0;
    bit   rst_at_edge = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: wrap the signed difference, borrow when a < b + bin.
    function automatic res_t model(input int unsigned av, input int unsigned bv, input int unsigned bi);
        res_t r;
        int   diff;
        diff = int'(av) - int'(bv) - int'(bi);
        r.d  = diff[N-1:0];
        r.bo = (av < bv + bi);
        return r;
    endfunction

    always @(posedge clk) rst_at_edge = !n_rst;

    // Monitor: outputs must hold the last published result except on a done pulse.
    always @(negedge clk) begin
        if (rst_at_edge) begin
            exp_q.delete();
            hold = '0;
            check("rst_busy", {31'b0, busy}, 0);
            check("rst_done", {31'b0, done}, 0);
            check("rst_difference", {24'b0, difference}, 0);
            check("rst_borrow_out", {31'b0, borrow_out}, 0);
        end else begin
            check("busy_done_excl", {31'b0, busy & done}, 0);
            if (done) begin
                if (exp_q.size() == 0) check("spurious_done", 1, 0);
                else hold = exp_q.pop_front();
            end
            check("difference", {24'b0, difference}, {24'b0, hold.d});
            check("borrow_out", {31'b0, borrow_out}, {31'b0, hold.bo});
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+#1; returns at posedge+#1 inside the DONE cycle.
    task automatic launch(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                          input bit perturb);
        a         = av;
        b         = bv;
        borrow_in = bi;
        start     = 1'b1;
        exp_q.push_back(model(av, bv, bi));
        @(posedge clk);
        #1;
        start     = 1'b0;
        // Scramble operands after capture; the in-flight result must not notice.
        a         = N'($urandom);
        b         = N'($urandom);
        borrow_in = 1'($urandom);
        check("busy_after_start", {30'b0, busy, done}, 32'b10);
        for (int i = 1; i < N; i++) begin
            @(posedge clk);
            #1;
            check("busy_shift", {30'b0, busy, done}, 32'b10);
            if (perturb && i == 2) begin
                a     = N'($urandom);
                b     = N'($urandom);
                start = 1'b1;
            end
            if (perturb && i == 4) start = 1'b0;
        end
        @(posedge clk);
        #1;
        check("done_latency", {30'b0, busy, done}, 32'b01);
    endtask

    initial begin
        n_rst     = 1'b0;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        borrow_in = 1'b0;
        idle(2);
        n_rst = 1'b1;
        idle(1);

        launch(8'd100, 8'd37, 1'b0, 1'b0);
        idle(2);
        launch(8'd5, 8'd10, 1'b0, 1'b0);
        idle(1);
        launch(8'h00, 8'h00, 1'b1, 1'b0);
        idle(1);
        launch(8'hFF, 8'hFF, 1'b1, 1'b0);
        idle(1);
        launch(8'hFF, 8'h00, 1'b0, 1'b0);
        idle(2);
        launch(8'd200, 8'd50, 1'b0, 1'b1);
        launch(8'd9, 8'd3, 1'b0, 1'b0);      // back-to-back from the DONE cycle
        idle(3);

        // Reset asserted for edge 4 of an in-flight operation; no result expected.
        a     = 8'd77;
        b     = 8'd12;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(3);
        n_rst = 1'b0;
        idle(1);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_done", {31'b0, done}, 0);
        check("abort_difference", {24'b0, difference}, 0);
        n_rst = 1'b1;
        idle(N + 4);
        launch(8'd9, 8'd3, 1'b1, 1'b0);
        idle(1);

        for (int k = 0; k < 40; k++) begin
            launch(N'($urandom), N'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end

        idle(3);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial, multi-cycle subtractor computing `a - b - borrow_in` one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse arithmetic companion to the team's combinational n-bit ripple-carry adder. It trades latency for a single-bit full-subtractor datapath, and sits in datapaths where area matters more than throughput. Results are registered and held until the next operation completes.

## Interface
- `NUM_BITS`, default 8: operand and result width. Legal values are ≥ 2.

- `clk` input, 1: the single system clock; all state updates on its rising edge.
- `n_rst` input, 1: reset, synchronous and active-low.
- `start` input, 1: request an operation. Sampled only in IDLE or DONE.
- `a` input, NUM_BITS: minuend (unsigned). Captured on the accepted `start` edge.
- `b` input, NUM_BITS: subtrahend (unsigned). Captured on the accepted `start` edge.
- `borrow_in` input, 1: incoming borrow. Captured on the accepted `start` edge.
- `busy` output, 1: high while shifting.
- `done` output, 1: single-cycle pulse when the result is valid.
- `difference` output, NUM_BITS: registered result, `(a - b - borrow_in) mod 2^NUM_BITS`.
- `borrow_out` output, 1: registered final borrow. High when `a < b + borrow_in`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `start`=1 loads the operand shift registers A←a, B←b and BR←borrow_in.
  - Clears the bit counter and the internal difference shift register D.
  - Next state is SHIFT.
  - `start`=0 stays in IDLE.
- SHIFT, each cycle:
  - Compute d = A[0] ^ B[0] ^ BR.
  - Compute BR ← (~A[0] & B[0]) | (~(A[0] ^ B[0]) & BR).
  - Shift A and B right by one.
  - Shift D right, inserting d at D[NUM_BITS-1].
  - Increment the counter.
  - After the NUM_BITS-th shift: `difference` ← D (including the final d), `borrow_out` ← BR, next state is DONE.
- DONE:
  - `done`=1 for exactly this cycle.
  - `start`=1 is accepted exactly as in IDLE, giving a back-to-back operation with next state SHIFT.
  - Otherwise the next state is IDLE.
- `start` in SHIFT is ignored; no queuing.
- Changes on `a`, `b` or `borrow_in` after capture have no effect on the in-flight operation.
- `difference` and `borrow_out` change only on the cycle entering DONE, or on reset. They are held otherwise, including across IDLE and the next operation's SHIFT cycles.
- Arithmetic identity, usable by the bench as a golden model:
  - `difference` equals the low NUM_BITS of `a + ~b + ~borrow_in`.
  - `borrow_out` equals the inverse of that sum's carry-out.
- Counter width is ceil(log2(NUM_BITS+1)). It never wraps within an operation.

## Timing
- Reset (`n_rst`=0 at a rising edge):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `difference`=0, `borrow_out`=0.
  - Internal A, B, D, BR and the counter are all cleared.
  - Reset overrides `start` in the same cycle.
  - Reset mid-SHIFT aborts the operation. No `done` is produced and the previous result is lost.
- Latency:
  - `start` accepted at edge 0.
  - `busy`=1 from edge 0 through edge NUM_BITS-1, i.e. NUM_BITS cycles.
  - State becomes DONE at edge NUM_BITS. `done`=1 and `busy`=0 in the cycle following edge NUM_BITS.
  - `difference` and `borrow_out` are valid from that same cycle.
  - For NUM_BITS=8: `done` is high in the 9th cycle after the start edge (edge 8).
- Throughput: back-to-back operations accepted in DONE give one result every NUM_BITS+1 cycles.
- `busy` and `done` are never high simultaneously.
- All outputs are driven from registers, with no combinational path from inputs.

## Test plan
- Basic subtraction, NUM_BITS=8: a=100, b=37, borrow_in=0, pulse `start`. Required: `busy` high for 8 cycles, `done` pulse at edge 8, `difference`=63, `borrow_out`=0.
- Underflow: a=5, b=10, borrow_in=0. Required: `difference`=0xFB, `borrow_out`=1.
- Borrow edge cases:
  - a=0x00, b=0x00, borrow_in=1 → `difference`=0xFF, `borrow_out`=1.
  - a=0xFF, b=0xFF, borrow_in=1 → 0xFF, 1.
  - a=0xFF, b=0x00, borrow_in=0 → 0xFF, 0.
- Input isolation and ignored start: start a=200, b=50. During SHIFT, change a/b and assert `start` again. Required: single `done`, `difference`=150, `borrow_out`=0, no second operation launched.
- Back-to-back operation: assert `start` with a=9, b=3 in the DONE cycle of a prior op. Required: `busy` the next cycle, `difference` holds the old result until the new DONE, then reads 6.
- Reset mid-operation: drop `n_rst` at edge 4 of SHIFT. Required: next cycle `busy`=0, `done`=0, `difference`=0, `borrow_out`=0, state IDLE, and no `done` ever for the aborted op. A subsequent `start` works normally.
